// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline definitions: opcodes, forward sources,
// hazard FSM states and operand-usage decode helpers.
package rv32_pipe_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_EXE,
    FWD_ACC,
    FWD_WB
  } fwd_src_t;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } hz_state_t;

  function automatic logic writes_rd(input logic [6:0] op);
    return op inside {OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD};
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return op inside {OP, OP_IMM, LOAD, STORE, BRANCH, JALR};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {OP, STORE, BRANCH};
  endfunction

  function automatic logic is_jump(input logic [6:0] op);
    return op inside {JAL, JALR};
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forward selector: youngest matching writer wins,
// an EXE load match raises load_use instead of forwarding.
module hazard_fwd_sel
  import rv32_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               rs_en,
  input  logic [RADDR_W-1:0] rs,
  input  logic [XLEN-1:0]    data_rf,
  input  logic               wr_exe,
  input  logic [RADDR_W-1:0] rd_exe,
  input  logic               ld_exe,
  input  logic [XLEN-1:0]    d_exe,
  input  logic               wr_acc,
  input  logic [RADDR_W-1:0] rd_acc,
  input  logic [XLEN-1:0]    d_acc,
  input  logic               wr_wb,
  input  logic [RADDR_W-1:0] rd_wb,
  input  logic [XLEN-1:0]    d_wb,
  output fwd_src_t           src,
  output logic [XLEN-1:0]    data,
  output logic               load_use,
  output logic               hit
);

  logic rd_ok;
  logic m_exe;
  logic m_acc;
  logic m_wb;

  assign rd_ok = rs_en && (rs != '0);
  assign m_exe = rd_ok && wr_exe && (rd_exe == rs);
  assign m_acc = rd_ok && wr_acc && (rd_acc == rs);
  assign m_wb  = rd_ok && wr_wb  && (rd_wb  == rs);
  assign hit   = m_exe || m_acc || m_wb;

  // Pick the youngest writer; a load still in EXE has no data yet
  always_comb begin
    src      = FWD_NONE;
    data     = data_rf;
    load_use = 1'b0;
    if (m_exe) begin
      if (ld_exe) begin
        load_use = 1'b1;
      end else begin
        src  = FWD_EXE;
        data = d_exe;
      end
    end else if (m_acc) begin
      src  = FWD_ACC;
      data = d_acc;
    end else if (m_wb) begin
      src  = FWD_WB;
      data = d_wb;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// RAW forwarding, load-use stall, branch redirect/flush control
// and saturating stall/flush counters for the 5-stage pipeline.
module hazard_fwd_unit
  import rv32_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RADDR_W   = 5,
  parameter int FLUSH_CYC = 2,
  parameter int FWD_EN    = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_de,
  input  logic             valid_de,
  input  logic [XLEN-1:0]  data_a_de,
  input  logic [XLEN-1:0]  data_b_de,
  input  logic [31:0]      instr_exe,
  input  logic             valid_exe,
  input  logic [XLEN-1:0]  alu_out_exe,
  input  logic [XLEN-1:0]  pc_exe,
  input  logic             br_taken_exe,
  input  logic [31:0]      instr_acc,
  input  logic             valid_acc,
  input  logic [XLEN-1:0]  alu_out_acc,
  input  logic [XLEN-1:0]  dmem_out_acc,
  input  logic [XLEN-1:0]  pc_4_acc,
  input  logic [31:0]      instr_wb,
  input  logic             valid_wb,
  input  logic [XLEN-1:0]  data_d_wb,
  output logic [XLEN-1:0]  data_a_mgr,
  output logic [XLEN-1:0]  data_b_mgr,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic             stall,
  output logic             pc_sel,
  output logic             false_path,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FC_LOAD = 3'(FLUSH_CYC - 1);

  hz_state_t state;
  logic [2:0] fcnt;

  logic [6:0] op_de, op_exe, op_acc, op_wb;
  logic [RADDR_W-1:0] rd_exe, rd_acc, rd_wb;
  logic de_ok, wr_exe, wr_acc, wr_wb, ld_exe;
  logic [XLEN-1:0] d_exe, d_acc;
  logic redirect, stall_raw;
  fwd_src_t src_a, src_b;
  logic [XLEN-1:0] sel_a, sel_b;
  logic lu_a, lu_b, hit_a, hit_b;
  logic unused;

  assign op_de  = instr_de[6:0];
  assign op_exe = instr_exe[6:0];
  assign op_acc = instr_acc[6:0];
  assign op_wb  = instr_wb[6:0];
  assign rd_exe = instr_exe[7 +: RADDR_W];
  assign rd_acc = instr_acc[7 +: RADDR_W];
  assign rd_wb  = instr_wb[7 +: RADDR_W];

  assign unused = ^{instr_de[31:25], instr_de[14:7],
                    instr_exe[31:12], instr_acc[31:12],
                    instr_wb[31:12]};

  assign de_ok  = !rst && valid_de && (state == ST_RUN);
  assign wr_exe = valid_exe && writes_rd(op_exe) && (rd_exe != '0);
  assign wr_acc = valid_acc && writes_rd(op_acc) && (rd_acc != '0);
  assign wr_wb  = valid_wb  && writes_rd(op_wb)  && (rd_wb  != '0);
  assign ld_exe = (op_exe == LOAD);

  assign d_exe = is_jump(op_exe) ? pc_exe + XLEN'(4) : alu_out_exe;
  assign d_acc = (op_acc == LOAD)  ? dmem_out_acc :
                 is_jump(op_acc)   ? pc_4_acc     : alu_out_acc;

  assign redirect = !rst && (state == ST_RUN) && valid_exe &&
                    (is_jump(op_exe) ||
                     ((op_exe == BRANCH) && br_taken_exe));

  hazard_fwd_sel #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_sel_a (
    .rs_en(de_ok && reads_rs1(op_de)),
    .rs(instr_de[15 +: RADDR_W]), .data_rf(data_a_de),
    .wr_exe(wr_exe), .rd_exe(rd_exe), .ld_exe(ld_exe), .d_exe(d_exe),
    .wr_acc(wr_acc), .rd_acc(rd_acc), .d_acc(d_acc),
    .wr_wb(wr_wb), .rd_wb(rd_wb), .d_wb(data_d_wb),
    .src(src_a), .data(sel_a), .load_use(lu_a), .hit(hit_a)
  );

  hazard_fwd_sel #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_sel_b (
    .rs_en(de_ok && reads_rs2(op_de)),
    .rs(instr_de[20 +: RADDR_W]), .data_rf(data_b_de),
    .wr_exe(wr_exe), .rd_exe(rd_exe), .ld_exe(ld_exe), .d_exe(d_exe),
    .wr_acc(wr_acc), .rd_acc(rd_acc), .d_acc(d_acc),
    .wr_wb(wr_wb), .rd_wb(rd_wb), .d_wb(data_d_wb),
    .src(src_b), .data(sel_b), .load_use(lu_b), .hit(hit_b)
  );

  // Without forwarding every match waits for the writer to retire
  always_comb begin
    if (FWD_EN != 0) begin
      hazard_a   = (src_a != FWD_NONE);
      hazard_b   = (src_b != FWD_NONE);
      data_a_mgr = sel_a;
      data_b_mgr = sel_b;
      stall_raw  = lu_a || lu_b;
    end else begin
      hazard_a   = 1'b0;
      hazard_b   = 1'b0;
      data_a_mgr = data_a_de;
      data_b_mgr = data_b_de;
      stall_raw  = hit_a || hit_b;
    end
  end

  assign stall      = stall_raw && !redirect;
  assign pc_sel     = redirect;
  assign false_path = !rst && (redirect || (state == ST_FLUSH));

  // Redirect FSM: hold the squash for the remaining flush cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      fcnt  <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (redirect && (FLUSH_CYC > 1)) begin
            fcnt  <= FC_LOAD;
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          fcnt <= fcnt - 3'd1;
          if (fcnt == 3'd1) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_sel && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard and forwarding manager for the RV32 five-stage pipeline: fetch, decode (DE), execute (EXE), access (ACC), writeback (WB).
- Resolves read-after-write hazards on both decode operands by forwarding from EXE, ACC or WB. Inserts a load-use stall when data cannot be forwarded yet.
- Drives PC redirect and a multi-cycle flush of younger stages on a taken branch or jump in EXE.
- Keeps saturating stall and flush performance counters.

Parameters:
XLEN, 32, datapath width of all operand and result buses
RADDR_W, 5, register-index width (rd, rs1, rs2 fields)
FLUSH_CYC, 2, cycles flush is held after a redirect (1..7)
FWD_EN, 1, 1 = forward; 0 = stall on every RAW hazard until the writer retires from WB
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_de  in  32  instruction in decode
valid_de  in  1  decode slot holds a real instruction
data_a_de  in  XLEN  register-file rs1 read
data_b_de  in  XLEN  register-file rs2 read
instr_exe  in  32  instruction in execute
valid_exe  in  1  execute slot valid
alu_out_exe  in  XLEN  EXE ALU result
pc_exe  in  XLEN  EXE program counter
br_taken_exe  in  1  branch comparator says taken (EXE)
instr_acc  in  32  instruction in access
valid_acc  in  1  access slot valid
alu_out_acc  in  XLEN  ACC ALU result
dmem_out_acc  in  XLEN  ACC load data
pc_4_acc  in  XLEN  ACC pc+4
instr_wb  in  32  instruction in writeback
valid_wb  in  1  writeback slot valid
data_d_wb  in  XLEN  WB write data
data_a_mgr  out  XLEN  resolved rs1 operand
data_b_mgr  out  XLEN  resolved rs2 operand
hazard_a  out  1  rs1 taken from forward path
hazard_b  out  1  rs2 taken from forward path
stall  out  1  hold fetch/decode, bubble into EXE
pc_sel  out  1  redirect PC to EXE target
false_path  out  1  flush (squash) fetch and decode
stall_cnt  out  CNT_W  stall cycles since reset
flush_cnt  out  CNT_W  redirect events since reset

Behaviour:
- Clocking: single clock domain; reset synchronous, active-high.
- Writer qualification: a stage is a writer only if its valid is 1, rd != 0, and its opcode writes rd (OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD). BRANCH and STORE never write.
- Reader qualification:
  - rs1 is read by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is read by OP, STORE, BRANCH.
  - Unread operands never flag a hazard; x0 never matches.
- Source selection per writer stage:
  - EXE: ALU ops → alu_out_exe; JAL/JALR → pc_exe+4 (XLEN wrap); LOAD → not forwardable.
  - ACC: LOAD → dmem_out_acc; ALU ops → alu_out_acc; JAL/JALR → pc_4_acc.
  - WB: data_d_wb.
- Priority: evaluated independently for rs1 and rs2, youngest writer first (EXE > ACC > WB). Both operands may forward in the same cycle.
- No match: data_*_mgr = data_*_de and hazard_* = 0.
- Forward path latency: forwarding is combinational, zero cycles.
- Load-use: EXE LOAD matching a read operand of a valid DE instruction → stall = 1 for that cycle. Next cycle the load is in ACC and forwards.
- FWD_EN = 0: hazard_* stay 0 and data_*_mgr = data_*_de. stall = 1 while any qualifying EXE/ACC/WB match exists.
- FSM states: RUN, FLUSH; flush down-counter fcnt.
  - RUN: valid_exe and (JAL, JALR, or BRANCH with br_taken_exe) → pc_sel = 1 and false_path = 1 this cycle. If FLUSH_CYC > 1, load fcnt = FLUSH_CYC-1 and go to FLUSH.
  - FLUSH: false_path = 1; pc_sel = 0; stall forced 0; decode treated as invalid (no hazards flagged). fcnt decrements each cycle; return to RUN when fcnt reaches 0 (the last FLUSH cycle).
- Redirect vs stall: a redirect in the same cycle as a stall condition takes precedence and forces stall = 0. A redirect while in FLUSH is ignored, since the EXE instruction is already squashed.
- Counters:
  - stall_cnt increments at each clock edge where stall = 1.
  - flush_cnt increments on each cycle where pc_sel = 1.
  - Both saturate at all-ones and never wrap.
- Reset, including reset asserted mid-FLUSH:
  - Next edge: state = RUN, fcnt = 0, both counters = 0.
  - While rst is high: stall = 0, pc_sel = 0, false_path = 0, hazard_* = 0, data_*_mgr = data_*_de.

Decomposition:
- Shared package rv32_pipe_pkg holds:
  - opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE);
  - fwd_src enum (NONE, EXE, ACC, WB);
  - FSM state enum;
  - writes_rd / reads_rs1 / reads_rs2 decode functions.
- Sub-module hazard_fwd_sel (instantiated twice, once per operand): given rs and the three stage descriptors, returns the selected source, the data, and a load-use flag.

Test Plan:
1. EXE `add x5,x1,x2`, alu_out_exe = 0x0000_00AA; DE `sub x6,x5,x5` → data_a_mgr = data_b_mgr = 0xAA, hazard_a = hazard_b = 1, stall = 0.
2. EXE writes x5 = 0x11, ACC writes x5 = 0x22, WB writes x5 = 0x33; DE reads x5 → 0x11 (EXE wins). With EXE invalid → 0x22.
3. EXE `lw x7`; DE `add x8,x7,x0` → stall = 1 for exactly one cycle. Next cycle ACC dmem_out_acc = 0xDEAD_BEEF forwards; stall_cnt = 1.
4. EXE writer with rd = x0, alu_out_exe = 0x55; DE reads x0 → hazard_a = 0, data_a_mgr = data_a_de = 0.
5. EXE BEQ with br_taken_exe = 1, FLUSH_CYC = 2 → pc_sel = 1 for 1 cycle, false_path = 1 for 2 cycles, flush_cnt = 1. A load-use match during the flush window gives stall = 0.
6. rst pulsed during the second FLUSH cycle → next cycle false_path = 0, state RUN, counters 0. With CNT_W = 2 and 5 stalls, stall_cnt holds 3.
